// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller and its interrupt front end.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding for the interrupt request controller, default
// handler-vector placement, and a helper that sizes source-id fields.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } irq_state_e;

    localparam logic [31:0] DEF_VEC_BASE  = 32'h0000_0100;
    localparam int unsigned DEF_VEC_SHIFT = 4;

    // Width of an id that can name n sources; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_pending_latch.sv
// Edge-detects raw interrupt lines and holds them as pending events.
// Latency: a rising edge sampled at clock edge k is visible on pending_o after edge k.
// Backpressure: none; events are latched unconditionally, clr_i/flush_i retire them.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   src_i       raw interrupt lines, synchronous to clk
//   clr_i       one-hot claim mask; a new edge on the same bit wins over the clear
//   flush_i     synchronous clear of every pending bit, discarding same-cycle edges
//   pending_o   latched pending events
module irq_pending_latch #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [NUM_SRC-1:0] clr_i,
    input  logic               flush_i,
    output logic [NUM_SRC-1:0] pending_o
);

    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] edge_det;

    always_comb begin
        // src_prev tracks the lines even during a flush so that a line held
        // high across the flush does not produce a spurious edge afterwards.
        src_prev_d = src_i;
        edge_det   = src_i & ~src_prev_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~clr_i) | edge_det;
        end
    end

    // src_prev resets to 0 so a line already high at reset release is an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/irq_request_controller.sv
// Latches, masks and prioritises interrupt sources and runs the claim/service/return handshake.
// Latency: src_i edge at clock k -> pending after k -> irq_o/irq_id_o/irq_vector_o after k+1.
// Backpressure: a locked request is held until ack_i (or flush_i); only one handler in service.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   src_i                 raw interrupt lines (rising edge = event)
//   en_we, en_wdata       enable-mask write port; en_o reflects the current mask
//   pending_o             latched events, independent of the mask
//   ack_i                 claim from the controller (honoured only while requesting)
//   ret_i                 handler return (honoured only while in service)
//   flush_i               synchronous clear of pending and handshake state; keeps the mask
//   irq_o                 registered request to the controller
//   irq_id_o              locked source id (kept after return)
//   irq_vector_o          VEC_BASE + (irq_id_o << VEC_SHIFT)
//   in_service_o          a handler is running
module irq_request_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [31:0] VEC_BASE  = DEF_VEC_BASE,
    parameter int unsigned VEC_SHIFT = DEF_VEC_SHIFT,
    parameter int unsigned ID_W      = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    output logic [NUM_SRC-1:0] en_o,
    output logic [NUM_SRC-1:0] pending_o,
    input  logic               ack_i,
    input  logic               ret_i,
    input  logic               flush_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [31:0]        irq_vector_o,
    output logic               in_service_o
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        vec_q, vec_d;
    logic               in_service_q, in_service_d;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    pick;

    irq_pending_latch #(
        .NUM_SRC (NUM_SRC)
    ) u_pending (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_i     (src_i),
        .clr_i     (clr),
        .flush_i   (flush_i),
        .pending_o (pending)
    );

    assign eligible = pending & en_q;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        pick = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        en_d         = en_we ? en_wdata : en_q;
        irq_d        = irq_q;
        id_d         = id_q;
        vec_d        = vec_q;
        in_service_d = in_service_q;
        clr          = '0;

        if (flush_i) begin
            // id/vector are deliberately left alone: they always show the last lock.
            state_d      = ST_IDLE;
            irq_d        = 1'b0;
            in_service_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (eligible != '0) begin
                        state_d = ST_REQ;
                        irq_d   = 1'b1;
                        id_d    = pick;
                        vec_d   = VEC_BASE + (32'(pick) << VEC_SHIFT);
                    end
                end
                ST_REQ: begin
                    // The mask is not consulted here: the controller may already
                    // have committed to this request, so it stays up until claimed.
                    if (ack_i) begin
                        state_d      = ST_SERVICE;
                        irq_d        = 1'b0;
                        in_service_d = 1'b1;
                        clr          = NUM_SRC'(1) << id_q;
                    end
                end
                ST_SERVICE: begin
                    // Returning always passes through IDLE for at least one cycle.
                    if (ret_i) begin
                        state_d      = ST_IDLE;
                        in_service_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    irq_d        = 1'b0;
                    in_service_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            en_q         <= '0;
            irq_q        <= 1'b0;
            id_q         <= '0;
            vec_q        <= VEC_BASE;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            irq_q        <= irq_d;
            id_q         <= id_d;
            vec_q        <= vec_d;
            in_service_q <= in_service_d;
        end
    end

    assign en_o         = en_q;
    assign pending_o    = pending;
    assign irq_o        = irq_q;
    assign irq_id_o     = id_q;
    assign irq_vector_o = vec_q;
    assign in_service_o = in_service_q;

endmodule
